// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter: keeps the k smallest distances of one query in a sorted
// shift-insertion array, then drains them in ascending order.
// Ports: clk; reset (synchronous, active-high); start/k open a query;
//   in_valid/in_ready/in_value/in_last carry the distance stream;
//   out_valid/out_ready/out_id/out_value/out_last carry the results;
//   busy = not idle; count = occupied slots (saturates at the latched k).
// Option macro KNN_TOPK_LABEL_EN: adds label_in, whose value is stored as
//   the entry ID in place of the internal INSTANCE/NUM_CH counter.
module knn_topk_sorter #(
    parameter int VAL_WIDTH = 32,
    parameter int ID_WIDTH  = 32,
    parameter int MAX_K     = 64,
    parameter int NUM_CH    = 1,
    parameter int INSTANCE  = 0,
    localparam int KW = $clog2(MAX_K + 1),
    localparam int PW = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        k,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VAL_WIDTH-1:0] in_value,
    input  logic                 in_last,
`ifdef KNN_TOPK_LABEL_EN
    input  logic [ID_WIDTH-1:0]  label_in,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_WIDTH-1:0]  out_id,
    output logic [VAL_WIDTH-1:0] out_value,
    output logic                 out_last,
    output logic                 busy,
    output logic [KW-1:0]        count
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t state;
    state_t stateNext;

    logic [KW-1:0]        kLat;
    logic [PW-1:0]        ptr;
    logic [MAX_K-1:0]     occ;
    logic [MAX_K-1:0]     cmp;
    logic [VAL_WIDTH-1:0] val [MAX_K];
    logic [ID_WIDTH-1:0]  ids [MAX_K];
    logic [ID_WIDTH-1:0]  newId;
    logic                 accept;
    logic                 outFire;
    logic                 startIdle;
    logic                 lastSlot;

    function automatic logic [KW-1:0] clampK(input logic [KW-1:0] kk);
        logic [KW-1:0] r;
        r = kk;
        if (kk == '0) r = KW'(1);
        else if (kk > KW'(MAX_K)) r = KW'(MAX_K);
        return r;
    endfunction

    assign accept    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign startIdle = start & (state == IDLE);
    assign lastSlot  = (KW'(ptr) == count - KW'(1));

`ifdef KNN_TOPK_LABEL_EN
    assign newId = label_in;
`else
    logic [ID_WIDTH-1:0] entryId;
    assign newId = entryId;

    always_ff @(posedge clk) begin
        if (reset || startIdle) entryId <= ID_WIDTH'(INSTANCE);
        else if (accept) entryId <= entryId + ID_WIDTH'(NUM_CH);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = FILL;
            FILL:    if (accept && in_last) stateNext = DRAIN;
            DRAIN:   if (outFire && out_last) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs: pure decodes of registered state; data gated outside DRAIN
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
        busy      = (state != IDLE);
        out_last  = out_valid && lastSlot;
        out_value = out_valid ? val[ptr] : '0;
        out_id    = out_valid ? ids[ptr] : '0;
    end

    // A slot takes the new value if it is empty or holds a strictly larger
    // value; strictness keeps equal values in arrival order.
    always_comb begin
        for (int i = 0; i < MAX_K; i++) begin
            cmp[i] = (KW'(i) < kLat) && (!occ[i] || (in_value < val[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || startIdle) begin
            occ <= '0;
        end else if (accept) begin
            for (int i = MAX_K - 1; i > 0; i--) begin
                if (cmp[i]) occ[i] <= cmp[i-1] ? occ[i-1] : 1'b1;
            end
            if (cmp[0]) occ[0] <= 1'b1;
        end
    end

    // Payload needs no reset: occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = MAX_K - 1; i > 0; i--) begin
                if (cmp[i]) begin
                    val[i] <= cmp[i-1] ? val[i-1] : in_value;
                    ids[i] <= cmp[i-1] ? ids[i-1] : newId;
                end
            end
            if (cmp[0]) begin
                val[0] <= in_value;
                ids[0] <= newId;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kLat  <= KW'(1);
            ptr   <= '0;
            count <= '0;
        end else begin
            if (startIdle) begin
                kLat  <= clampK(k);
                ptr   <= '0;
                count <= '0;
            end
            if (accept && (count < kLat)) count <= count + KW'(1);
            if (outFire) ptr <= out_last ? '0 : ptr + PW'(1);
        end
    end
endmodule
